// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU command controller and the 4-bit ALU:
// opcode / ALU select encoding, controller state encoding, operand width.
package alu_ctrl_pkg;

    localparam int OPW = 4;

    // Opcodes 000..100 are also the ALU select encoding.
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // True for opcodes executed in a single pass through the ALU.
    function automatic logic is_alu_op(input logic [2:0] op);
        return (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/simple_alu.sv
// Team 4-bit combinational ALU. SUB reports cout=1 when no borrow (a >= b);
// logic ops and unused selects report cout=0.
module simple_alu
    import alu_ctrl_pkg::*;
(
    input  logic [OPW-1:0] a,
    input  logic [OPW-1:0] b,
    input  logic [2:0]     sel,
    output logic [OPW-1:0] result,
    output logic           cout
);

    logic [OPW:0] wide;

    // Result and carry selection by operation.
    always_comb begin
        wide   = '0;
        result = '0;
        cout   = 1'b0;
        case (sel)
            OP_ADD: begin
                wide   = {1'b0, a} + {1'b0, b};
                result = wide[OPW-1:0];
                cout   = wide[OPW];
            end
            OP_SUB: begin
                wide   = {1'b0, a} - {1'b0, b};
                result = wide[OPW-1:0];
                cout   = ~wide[OPW];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command front-end for simple_alu: accepts one command at a time, runs it
// through the external ALU (single pass, or four shift-add passes for MUL)
// and holds a registered response until the consumer takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. cmd_ready is 1 only in IDLE. rsp_valid is 1 only in RESP and the
// rsp_* values stay constant until the edge where rsp_ready is seen.
module alu_cmd_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int MUL_STEPS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
    input  logic [OPW-1:0] cmd_a,
    input  logic [OPW-1:0] cmd_b,
    output logic [OPW-1:0] alu_a,
    output logic [OPW-1:0] alu_b,
    output logic [2:0]     alu_sel,
    input  logic [OPW-1:0] alu_result,
    input  logic           alu_cout,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [7:0]     rsp_result,
    output logic           rsp_cout,
    output logic           rsp_zero,
    output logic           rsp_err,
    output logic [1:0]     dbg_state
);

    state_e         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [OPW-1:0] hi_q, hi_d;
    logic [OPW-1:0] lo_q, lo_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [7:0]     result_q, result_d;
    logic           cout_q, cout_d;
    logic           err_q, err_d;

    // Shift-add step values for the multiplier.
    logic           mul_c;
    logic [OPW-1:0] mul_s;
    logic [7:0]     mul_next;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            err_q    <= err_d;
        end
    end

    // Next-state, datapath updates and ALU/handshake outputs.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        cout_d    = cout_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        alu_sel   = '0;
        mul_c     = 1'b0;
        mul_s     = '0;
        mul_next  = '0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    op_d = cmd_op;
                    a_d  = cmd_a;
                    b_d  = cmd_b;
                    if (is_alu_op(cmd_op)) begin
                        state_d = ST_EXEC;
                    end else if (cmd_op == OP_MUL) begin
                        hi_d    = '0;
                        lo_d    = cmd_b;
                        cnt_d   = '0;
                        state_d = ST_MUL;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                        cout_d   = 1'b0;
                        state_d  = ST_RESP;
                    end
                end
            end

            ST_EXEC: begin
                alu_a    = a_q;
                alu_b    = b_q;
                alu_sel  = op_q;
                result_d = {4'b0000, alu_result};
                cout_d   = alu_cout;
                err_d    = 1'b0;
                state_d  = ST_RESP;
            end

            ST_MUL: begin
                // hi accumulates a when the current multiplier bit is set,
                // then {carry, hi, lo} shifts right by one.
                alu_sel = OP_ADD;
                alu_a   = hi_q;
                alu_b   = a_q;
                if (lo_q[0]) begin
                    mul_c = alu_cout;
                    mul_s = alu_result;
                end else begin
                    mul_c = 1'b0;
                    mul_s = hi_q;
                end
                mul_next = {mul_c, mul_s, lo_q[3:1]};
                hi_d     = mul_next[7:4];
                lo_d     = mul_next[3:0];
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'(MUL_STEPS - 1)) begin
                    result_d = mul_next;
                    cout_d   = 1'b0;
                    err_d    = 1'b0;
                    state_d  = ST_RESP;
                end
            end

            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = result_q;
    assign rsp_cout   = cout_q;
    assign rsp_err    = err_q;
    assign rsp_zero   = (result_q == 8'h00);
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Bench for alu_cmd_ctrl wired back-to-back with simple_alu. Expected
// responses come from an arithmetic model of each opcode and sit in a queue
// until the matching response is presented.
module tb_alu_cmd_ctrl;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_sel;
    logic [3:0] alu_result;
    logic       alu_cout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_result;
    logic       rsp_cout;
    logic       rsp_zero;
    logic       rsp_err;
    logic [1:0] dbg_state;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected response packed as {err, cout, result[7:0]}.
    logic [9:0] exp_q[$];
    int         exp_lat;
    logic [2:0] cur_op;
    logic [3:0] cur_a;
    logic [3:0] cur_b;

    alu_cmd_ctrl #(.MUL_STEPS(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_cout   (alu_cout),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_zero   (rsp_zero),
        .rsp_err    (rsp_err),
        .dbg_state  (dbg_state)
    );

    simple_alu u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .sel    (alu_sel),
        .result (alu_result),
        .cout   (alu_cout)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (got timeout, want summary)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one command: response fields and latency.
    task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         output logic [9:0] pack, output int lat);
        int   r;
        logic c;
        logic e;
        r = 0; c = 1'b0; e = 1'b0; lat = 2;
        case (op)
            3'd0: begin r = int'(a) + int'(b); c = (r > 15); r = r % 16; end
            3'd1: begin c = (a >= b); r = (int'(a) - int'(b) + 16) % 16; end
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: begin r = int'(a) * int'(b); lat = 5; end
            default: begin e = 1'b1; lat = 1; end
        endcase
        pack = {e, c, r[7:0]};
    endtask

    // Present a command on the bus and record its expected response.
    task automatic prep(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [9:0] pack;
        int         lat;
        model(op, a, b, pack, lat);
        exp_q.push_back(pack);
        exp_lat   = lat;
        cur_op    = op;
        cur_a     = a;
        cur_b     = b;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
    endtask

    // Drive a command and return at the falling edge after its accept edge.
    task automatic start_cmd(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        prep(op, a, b);
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Measure response latency and compare the response with the model.
    task automatic wait_rsp();
        int         lat = 1;
        logic [9:0] exp;
        while (!rsp_valid && lat < 20) begin
            check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (lat == 1 && exp_lat == 2) begin
                check("exec_alu_a", 32'(alu_a), 32'(cur_a));
                check("exec_alu_b", 32'(alu_b), 32'(cur_b));
                check("exec_alu_sel", 32'(alu_sel), 32'(cur_op));
            end
            if (lat == 1 && exp_lat == 5) begin
                check("mul_alu_sel", 32'(alu_sel), 32'd0);
                check("mul_alu_a", 32'(alu_a), 32'd0);
                check("mul_alu_b", 32'(alu_b), 32'(cur_a));
            end
            @(negedge clk);
            lat++;
        end
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            check("exp_q_nonempty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("rsp_result", 32'(rsp_result), 32'(exp[7:0]));
            check("rsp_cout", 32'(rsp_cout), 32'(exp[8]));
            check("rsp_err", 32'(rsp_err), 32'(exp[9]));
            check("rsp_zero", 32'(rsp_zero), 32'(exp[7:0] == 8'h00));
            check("alu_idle_in_resp", 32'({alu_a, alu_b, alu_sel}), 32'd0);
        end
    endtask

    // Stall the response for hold cycles, then complete the handshake.
    task automatic finish_rsp(input int hold);
        logic [10:0] snap;
        snap = {rsp_zero, rsp_err, rsp_cout, rsp_result};
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            check("hold_rsp_stable", 32'({rsp_zero, rsp_err, rsp_cout, rsp_result}), 32'(snap));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("after_hs_rsp_valid", 32'(rsp_valid), 32'd0);
        check("after_hs_cmd_ready", 32'(cmd_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_result"}, 32'(rsp_result), 32'd0);
        check({tag, "_rsp_cout"}, 32'(rsp_cout), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_zero"}, 32'(rsp_zero), 32'd1);
        check({tag, "_alu"}, 32'({alu_a, alu_b, alu_sel}), 32'd0);
    endtask

    initial begin
        logic [2:0] r_op;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // ALU operations
        start_cmd(3'b000, 4'b1010, 4'b0101); wait_rsp(); finish_rsp(0);
        start_cmd(3'b001, 4'b1010, 4'b0101); wait_rsp(); finish_rsp(1);
        start_cmd(3'b001, 4'b0011, 4'b0011); wait_rsp(); finish_rsp(0);
        start_cmd(3'b001, 4'b0001, 4'b0010); wait_rsp(); finish_rsp(0);

        // Multiply
        start_cmd(3'b101, 4'b1111, 4'b1111); wait_rsp(); finish_rsp(0);
        start_cmd(3'b101, 4'b1010, 4'b0101); wait_rsp(); finish_rsp(0);
        start_cmd(3'b101, 4'b0000, 4'b1011); wait_rsp(); finish_rsp(0);

        // Illegal opcodes, then a legal command clears err
        start_cmd(3'b110, 4'b0110, 4'b0001); wait_rsp(); finish_rsp(0);
        start_cmd(3'b111, 4'b1111, 4'b1111); wait_rsp(); finish_rsp(0);
        start_cmd(3'b011, 4'b1100, 4'b0011); wait_rsp(); finish_rsp(0);

        // Back-pressured response with a command waiting behind it
        start_cmd(3'b100, 4'b1100, 4'b0110); wait_rsp();
        prep(3'b000, 4'b1111, 4'b0001);
        exp_q.push_front(exp_q.pop_back());
        // The queued entry must follow the response still being held.
        exp_q.push_back(exp_q.pop_front());
        finish_rsp(5);
        @(negedge clk);
        check("pending_accepted", 32'(cmd_ready), 32'd0);
        cmd_valid = 1'b0;
        wait_rsp(); finish_rsp(0);

        // Reset during the second multiply cycle
        start_cmd(3'b101, 4'b0111, 4'b0110);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        check_reset_values("mul_abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        start_cmd(3'b010, 4'b1100, 4'b1010); wait_rsp(); finish_rsp(0);

        // Random commands with random response stalls
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            start_cmd(r_op, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            wait_rsp();
            finish_rsp($urandom_range(0, 3));
        end

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
